exe_stage: RTL
==============

// Module: exe_stage
// PURPOSE
//  Execute stage of the 5-stage ARM pipeline, directly downstream of the ID/EX register. Forwards operands,
//  builds Val2 (rotated imm / shifted Rm / mem offset), runs the ALU, holds the NZCV status register,
//  computes the branch target and registers results into the EXE/MEM boundary (freezable for memory stalls).
// PARAMETERS
//  ADDRESS_LEN  32  datapath/address width (from configs.v)
// PORTS
//  clk              in   1    rising-edge clock
//  rst              in   1    synchronous, active-high reset
//  freeze           in   1    hold EXE/MEM regs and status reg this cycle
//  EXE_CMD          in   4    ALU op (encodings in configs.v)
//  S, B             in   1    update-status / branch flags from ID/EX
//  MEM_R_EN, MEM_W_EN, WB_EN  in  1  control from ID/EX
//  immediate        in   1    Val2 from shift_operand immediate form
//  pc               in   32   PC+4 of this instruction
//  val_Rn, val_Rm   in   32   register-file operands
//  signed_extend_immediate in 24  branch offset (words)
//  shift_operand    in   12   ARM shifter operand field
//  output_dst       in   4    destination register
//  sel_src1, sel_src2 in 2    forwarding select: 00 regfile, 01 mem_fwd_val, 10 wb_fwd_val, 11 regfile
//  mem_fwd_val, wb_fwd_val in 32  forwarded results from MEM / WB
//  branch_taken     out  1    = B (combinational)
//  branch_address   out  32   pc + (sext(imm24) << 2) (combinational)
//  status_out       out  4    current NZCV register {N,Z,C,V}
//  alu_result_out   out  32   registered ALU result / memory address
//  store_val_out    out  32   registered forwarded Rm (store data)
//  dst_out          out  4    registered destination
//  WB_EN_out, MEM_R_EN_out, MEM_W_EN_out out 1 registered control
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all registered outputs and NZCV <= 0; rst overrides freeze.
//  - Latency: 1 cycle; inputs at edge k appear on *_out after edge k. freeze=1: all regs hold.
//  - op1 = mux(sel_src1) of val_Rn; op2src = mux(sel_src2) of val_Rm; store_val = op2src.
//  - Val2: MEM_R_EN|MEM_W_EN -> {20'b0, shift_operand}; else immediate=1 -> {24'b0,imm8} ROR 2*rot4
//    (rot4=[11:8], imm8=[7:0]); else op2src shifted by [11:7] per type [6:5]: 00 LSL, 01 LSR, 10 ASR,
//    11 ROR; shift amount 0 = no shift for all types.
//  - ALU (C = status C): MOV 0001 val2; MVN 1001 ~val2; ADD 0010 op1+val2; ADC 0011 op1+val2+C;
//    SUB 0100 op1-val2; SBC 0101 op1-val2-!C; AND 0110; ORR 0111; EOR 1000; other codes -> 0, flags hold.
//  - Flags: N=res[31], Z=(res==0). Arithmetic: C=carry out of 33-bit sum (SUB/SBC: C = NOT borrow),
//    V = signed overflow. Logic/move: C,V preserved. CMP/TST reuse SUB/AND with WB_EN=0.
//  - NZCV written at posedge only when S=1 and freeze=0; status_out always the registered value.
//  - Branch outputs are unregistered; a flush upstream does not alter them.
// STRUCTURE
//  - configs.v: ADDRESS_LEN, EXE_CMD encodings, shift-type codes, forwarding-select codes.
//  - Sub-module val2_generator (combinational Val2); ALU and registers inline.
// TESTING
//  1 rst=1 for 2 cycles with random inputs -> all *_out=0, status_out=0000.
//  2 ADD, op1=0x7FFFFFFF, imm 1, S=1 -> alu_result_out=0x80000000, NZCV=1001 next cycle.
//  3 SUB op1=5, val2=5, S=1 -> result 0, NZCV=0110; then SBC 5-3 (C=1) -> 2, NZCV=0010.
//  4 Val2: imm8=0xFF rot4=4 -> 0xFF000000; Rm=0x80000000 ASR 4 -> 0xF8000000; ROR 0 unchanged.
//  5 sel_src1=01, mem_fwd_val=10, ADD val2=1 -> 11; freeze=1 with new op -> outputs and NZCV unchanged.
//  6 B=1, pc=0x100, imm24=0xFFFFFE -> branch_taken=1, branch_address=0xF8; STR -> store_val_out=fwd Rm.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: datapath width, ALU command
// encodings, shifter types, forwarding selects, status-flag layout and
// small helper functions used by the top and the Val2 generator.
package exe_stage_pkg;

  localparam int ADDRESS_LEN = 32;

  typedef enum logic [3:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10,
    FWD_RF2 = 2'b11
  } fwd_sel_e;

  // Status register layout, MSB first: {N,Z,C,V}
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // Rotate right; a zero amount leaves the value untouched because the
  // left shift by the full width yields zero.
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
    return (x >> amt) | (x << (6'd32 - {1'b0, amt}));
  endfunction

  // Operand forwarding: 00 and 11 both take the register-file value.
  function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] rf,
                                         input logic [31:0] mem, input logic [31:0] wb);
    logic [31:0] r;
    case (sel)
      FWD_MEM: r = mem;
      FWD_WB:  r = wb;
      default: r = rf;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exe_stage_val2_gen.sv
// Combinational second-operand (Val2) generator.
//  mem_en        in  1   load/store: Val2 is the zero-extended 12-bit offset
//  immediate     in  1   rotated 8-bit immediate form
//  shift_operand in  12  shifter operand field
//  rm            in  32  forwarded Rm value
//  val2          out 32  resulting second ALU operand
module exe_stage_val2_gen
  import exe_stage_pkg::*;
(
  input  logic                   mem_en,
  input  logic                   immediate,
  input  logic [11:0]            shift_operand,
  input  logic [ADDRESS_LEN-1:0] rm,
  output logic [ADDRESS_LEN-1:0] val2
);

  logic [3:0] rot4;
  logic [7:0] imm8;
  logic [4:0] amt;
  logic [1:0] sh_type;

  assign rot4    = shift_operand[11:8];
  assign imm8    = shift_operand[7:0];
  assign amt     = shift_operand[11:7];
  assign sh_type = shift_operand[6:5];

  // An amount of zero means "no shift" for every type (no RRX / #32 forms).
  always_comb begin
    val2 = rm;
    if (mem_en) begin
      val2 = {20'd0, shift_operand};
    end else if (immediate) begin
      val2 = ror32({24'd0, imm8}, {rot4, 1'b0});
    end else begin
      case (sh_type)
        SH_LSL:  val2 = rm << amt;
        SH_LSR:  val2 = rm >> amt;
        SH_ASR:  val2 = $unsigned($signed(rm) >>> amt);
        default: val2 = ror32(rm, amt);
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage of the 5-stage ARM pipeline. Forwards operands, builds Val2,
// runs the ALU, keeps the NZCV register, computes the branch target and
// registers results into the EXE/MEM boundary.
//  clk, rst                   clock, synchronous active-high reset
//  freeze                     hold EXE/MEM regs and NZCV this cycle
//  EXE_CMD, S, B              ALU op, status-update and branch flags
//  MEM_R_EN, MEM_W_EN, WB_EN  control from ID/EX
//  immediate, shift_operand   Val2 form select and shifter field
//  pc, val_Rn, val_Rm         PC+4 and register-file operands
//  signed_extend_immediate    24-bit word branch offset
//  output_dst                 destination register
//  sel_src1/2, *_fwd_val      forwarding selects and forwarded values
//  branch_taken/address       combinational branch outputs
//  status_out                 registered {N,Z,C,V}
//  *_out                      registered EXE/MEM results and control
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic [3:0]             EXE_CMD,
  input  logic                   S,
  input  logic                   B,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic                   WB_EN,
  input  logic                   immediate,
  input  logic [ADDRESS_LEN-1:0] pc,
  input  logic [ADDRESS_LEN-1:0] val_Rn,
  input  logic [ADDRESS_LEN-1:0] val_Rm,
  input  logic [23:0]            signed_extend_immediate,
  input  logic [11:0]            shift_operand,
  input  logic [3:0]             output_dst,
  input  logic [1:0]             sel_src1,
  input  logic [1:0]             sel_src2,
  input  logic [ADDRESS_LEN-1:0] mem_fwd_val,
  input  logic [ADDRESS_LEN-1:0] wb_fwd_val,
  output logic                   branch_taken,
  output logic [ADDRESS_LEN-1:0] branch_address,
  output logic [3:0]             status_out,
  output logic [ADDRESS_LEN-1:0] alu_result_out,
  output logic [ADDRESS_LEN-1:0] store_val_out,
  output logic [3:0]             dst_out,
  output logic                   WB_EN_out,
  output logic                   MEM_R_EN_out,
  output logic                   MEM_W_EN_out
);

  logic [ADDRESS_LEN-1:0] op1, op2src, val2;
  logic [ADDRESS_LEN-1:0] alu_res, add_b;
  logic [ADDRESS_LEN:0]   sum;
  logic                   add_cin;
  logic                   is_sub;
  nzcv_t                  status, flags_nxt;

  assign op1    = fwd_mux(sel_src1, val_Rn, mem_fwd_val, wb_fwd_val);
  assign op2src = fwd_mux(sel_src2, val_Rm, mem_fwd_val, wb_fwd_val);

  exe_stage_val2_gen u_val2 (
    .mem_en        (MEM_R_EN | MEM_W_EN),
    .immediate     (immediate),
    .shift_operand (shift_operand),
    .rm            (op2src),
    .val2          (val2)
  );

  assign branch_taken   = B;
  assign branch_address = pc + {{6{signed_extend_immediate[23]}}, signed_extend_immediate, 2'b00};

  assign is_sub = (EXE_CMD == EXE_SUB) || (EXE_CMD == EXE_SBC);

  always_comb begin
    alu_res   = '0;
    flags_nxt = status;
    add_b     = val2;
    add_cin   = 1'b0;
    sum       = '0;
    case (EXE_CMD)
      EXE_MOV: alu_res = val2;
      EXE_MVN: alu_res = ~val2;
      EXE_AND: alu_res = op1 & val2;
      EXE_ORR: alu_res = op1 | val2;
      EXE_EOR: alu_res = op1 ^ val2;
      EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC: begin
        // Subtract as op1 + ~val2 + cin so the carry out is NOT borrow;
        // SBC's "- !C" becomes "+ C" in this form, same as ADC.
        add_b   = is_sub ? ~val2 : val2;
        add_cin = (EXE_CMD == EXE_SUB) ? 1'b1 :
                  (EXE_CMD == EXE_ADD) ? 1'b0 : status.c;
        sum     = {1'b0, op1} + {1'b0, add_b} + {{ADDRESS_LEN{1'b0}}, add_cin};
        alu_res = sum[ADDRESS_LEN-1:0];
        flags_nxt.c = sum[ADDRESS_LEN];
        flags_nxt.v = (op1[ADDRESS_LEN-1] == add_b[ADDRESS_LEN-1]) &&
                      (alu_res[ADDRESS_LEN-1] != op1[ADDRESS_LEN-1]);
      end
      default: ;
    endcase
    // Unknown commands leave every flag as it was.
    if (EXE_CMD inside {EXE_MOV, EXE_MVN, EXE_AND, EXE_ORR, EXE_EOR,
                        EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC}) begin
      flags_nxt.n = alu_res[ADDRESS_LEN-1];
      flags_nxt.z = (alu_res == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status <= '0;
    end else if (!freeze && S) begin
      status <= flags_nxt;
    end
  end

  assign status_out = status;

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_out <= '0;
      store_val_out  <= '0;
      dst_out        <= '0;
      WB_EN_out      <= 1'b0;
      MEM_R_EN_out   <= 1'b0;
      MEM_W_EN_out   <= 1'b0;
    end else if (!freeze) begin
      alu_result_out <= alu_res;
      store_val_out  <= op2src;
      dst_out        <= output_dst;
      WB_EN_out      <= WB_EN;
      MEM_R_EN_out   <= MEM_R_EN;
      MEM_W_EN_out   <= MEM_W_EN;
    end
  end

endmodule
